// File: rtl/joypad_port_if.sv
// Signal bundle for the NES controller port: CPU-side strobe/read/data,
// the physical pad wires, and the committed button frames.
interface joypad_port_if;
  logic [2:0] ctrl_strobe;
  logic [1:0] ctrl_rd;
  logic [1:0] ctrl_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [1:0] pad_data;
  logic [7:0] buttons0;
  logic [7:0] buttons1;

  // master is the surrounding system (APU decode plus the pads); slave is the port block
  modport master (
    output ctrl_strobe, ctrl_rd, pad_data,
    input  ctrl_data, pad_latch, pad_clk, buttons0, buttons1
  );

  modport slave (
    input  ctrl_strobe, ctrl_rd, pad_data,
    output ctrl_data, pad_latch, pad_clk, buttons0, buttons1
  );
endinterface

// File: rtl/joypad_port.sv
// NES controller port: polls two physical pads over latch/clock/data and
// emulates the 4021 shift registers the CPU reads at $4016/$4017.
module joypad_port #(
  parameter int HALF        = 300,
  parameter int POLL_CYCLES = 357954
) (
  input  logic         clk,
  input  logic         rst,
  joypad_port_if.slave bus
);

  localparam int CNT_W = $clog2(POLL_CYCLES);
  localparam int PH_W  = $clog2(2 * HALF);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    COMMIT
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  poll_cnt;
  logic [PH_W-1:0]   phase, phase_nx;
  logic [2:0]        bit_idx, bit_idx_nx;
  logic              capture_en;
  logic              commit_en;
  logic [1:0]        sync1, sync2;
  logic [7:0]        cap0, cap1;
  logic [7:0]        btn0, btn1;
  logic [7:0]        sr0, sr1;
  logic [1:0]        unused_strobe_bits;

  assign unused_strobe_bits = bus.ctrl_strobe[2:1];

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == CNT_W'(POLL_CYCLES - 1)) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      bit_idx <= bit_idx_nx;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase + 1'b1;
    bit_idx_nx = bit_idx;
    capture_en = 1'b0;
    commit_en  = 1'b0;
    unique case (state)
      IDLE: begin
        phase_nx = '0;
        // Decide one cycle early so LATCH occupies the cycle the counter reads POLL_CYCLES-1.
        if (poll_cnt == CNT_W'(POLL_CYCLES - 2)) state_nx = LATCH;
      end
      LATCH: begin
        if (phase == PH_W'(2 * HALF - 1)) begin
          state_nx   = LOW;
          phase_nx   = '0;
          bit_idx_nx = '0;
        end
      end
      LOW: begin
        if (phase == PH_W'(HALF - 1)) begin
          capture_en = 1'b1;
          phase_nx   = '0;
          state_nx   = (bit_idx == 3'd7) ? COMMIT : HIGH;
        end
      end
      HIGH: begin
        if (phase == PH_W'(HALF - 1)) begin
          phase_nx   = '0;
          bit_idx_nx = bit_idx + 1'b1;
          state_nx   = LOW;
        end
      end
      COMMIT: begin
        commit_en = 1'b1;
        phase_nx  = '0;
        state_nx  = IDLE;
      end
      default: begin
        phase_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cap0  <= '0;
      cap1  <= '0;
      btn0  <= '0;
      btn1  <= '0;
    end else begin
      sync1 <= bus.pad_data;
      sync2 <= sync1;
      // Pad data is active-low on the wire; stored frames use 1 = pressed.
      if (capture_en) begin
        cap0[bit_idx] <= ~sync2[0];
        cap1[bit_idx] <= ~sync2[1];
      end
      if (commit_en) begin
        btn0 <= cap0;
        btn1 <= cap1;
      end
    end
  end

  // Strobe reload has priority over a read; exhausted registers shift in 1s.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr0 <= '0;
      sr1 <= '0;
    end else begin
      if (bus.ctrl_strobe[0])  sr0 <= btn0;
      else if (bus.ctrl_rd[0]) sr0 <= {1'b1, sr0[7:1]};
      if (bus.ctrl_strobe[0])  sr1 <= btn1;
      else if (bus.ctrl_rd[1]) sr1 <= {1'b1, sr1[7:1]};
    end
  end

  assign bus.pad_latch = (state == LATCH);
  assign bus.pad_clk   = (state == HIGH);
  assign bus.ctrl_data = {sr1[0], sr0[0]};
  assign bus.buttons0  = btn0;
  assign bus.buttons1  = btn1;

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: pad serial model, frame timing checks,
// and a vector table for the CPU-side shift registers.
module tb_joypad_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  joypad_port_if bus ();

  joypad_port #(.HALF(4), .POLL_CYCLES(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Pad model: 4021-like, reloads while latch is high, shifts on pad_clk rising edge.
  logic [7:0] pad_btn0 = 8'h09;
  logic [7:0] pad_btn1 = 8'hA0;
  logic [7:0] psr0 = 8'h00;
  logic [7:0] psr1 = 8'h00;
  logic       pclk_q = 1'b0;

  always @(posedge clk) begin
    pclk_q <= bus.pad_clk;
    if (bus.pad_latch) begin
      psr0 <= pad_btn0;
      psr1 <= pad_btn1;
    end else if (bus.pad_clk && !pclk_q) begin
      psr0 <= {1'b1, psr0[7:1]};
      psr1 <= {1'b1, psr1[7:1]};
    end
  end

  assign bus.pad_data = {~psr1[0], ~psr0[0]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [2:0] strobe;
    logic [1:0] rd;
    logic [1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [2:0] s, input logic [1:0] r, input logic [1:0] e);
    vecs.push_back(vec_t'{strobe: s, rd: r, exp_data: e});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the sample where the poll counter is 0 (just after reset release).
  task automatic check_idle_then_latch(input string tag);
    bit bad = 1'b0;
    if (bus.pad_latch || bus.pad_clk || bus.buttons0 != 8'h00) bad = 1'b1;
    for (int k = 1; k < 199; k++) begin
      tick();
      if (bus.pad_latch || bus.pad_clk || bus.buttons0 != 8'h00) bad = 1'b1;
    end
    check({tag, " idle lines low"}, 32'(bad), 32'(0));
    tick();
    check({tag, " latch at cycle 199"}, 32'(bus.pad_latch), 32'(1));
  endtask

  initial begin
    int lat_len, pulses, bad_len, run, commit_at, got;
    bit split, bad, found;
    logic prev_clk;
    bus.ctrl_strobe = 3'b000;
    bus.ctrl_rd     = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset pad_latch", 32'(bus.pad_latch), 32'(0));
    check("reset pad_clk", 32'(bus.pad_clk), 32'(0));
    check("reset buttons", 32'({bus.buttons1, bus.buttons0}), 32'(0));
    check("reset ctrl_data", 32'(bus.ctrl_data), 32'(0));

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_then_latch("first frame");

    // Frame shape, from the LATCH sample at cycle 199 through the commit
    lat_len = 0; pulses = 0; bad_len = 0; run = 0; commit_at = -1; split = 1'b0;
    for (int k = 199; k <= 270; k++) begin
      if (k > 199) tick();
      if (bus.pad_latch) lat_len++;
      if (bus.pad_clk) run++;
      else begin
        if (run != 0) begin
          pulses++;
          if (run != 4) bad_len++;
        end
        run = 0;
      end
      if ((bus.buttons0 != 8'h00) != (bus.buttons1 != 8'h00)) split = 1'b1;
      if (commit_at < 0 && bus.buttons0 != 8'h00) commit_at = k;
    end
    check("latch length", 32'(lat_len), 32'(8));
    check("pad_clk pulse count", 32'(pulses), 32'(7));
    check("pad_clk pulse widths off", 32'(bad_len), 32'(0));
    check("buttons updated together", 32'(split), 32'(0));
    check("commit visible cycle", 32'(commit_at), 32'(268));
    check("buttons0 frame", 32'(bus.buttons0), 32'(8'h09));
    check("buttons1 frame", 32'(bus.buttons1), 32'(8'hA0));

    // CPU-side vectors: {strobe, rd, expected ctrl_data sampled before the edge}
    add(3'b001, 2'b00, 2'b00);
    add(3'b000, 2'b00, 2'b01);
    add(3'b000, 2'b01, 2'b01); add(3'b000, 2'b01, 2'b00);
    add(3'b000, 2'b01, 2'b00); add(3'b000, 2'b01, 2'b01);
    add(3'b000, 2'b01, 2'b00); add(3'b000, 2'b01, 2'b00);
    add(3'b000, 2'b01, 2'b00); add(3'b000, 2'b01, 2'b00);
    add(3'b000, 2'b01, 2'b01); add(3'b000, 2'b01, 2'b01);
    add(3'b000, 2'b10, 2'b01); add(3'b000, 2'b10, 2'b01);
    add(3'b000, 2'b10, 2'b01); add(3'b000, 2'b10, 2'b01);
    add(3'b000, 2'b10, 2'b01); add(3'b000, 2'b10, 2'b11);
    add(3'b000, 2'b10, 2'b01); add(3'b000, 2'b10, 2'b11);
    add(3'b000, 2'b10, 2'b11);
    add(3'b001, 2'b11, 2'b11);
    add(3'b001, 2'b11, 2'b01);
    add(3'b001, 2'b01, 2'b01);
    add(3'b000, 2'b11, 2'b01);
    add(3'b000, 2'b11, 2'b00);
    add(3'b000, 2'b00, 2'b00);
    add(3'b000, 2'b01, 2'b00);
    add(3'b000, 2'b00, 2'b01);
    add(3'b110, 2'b01, 2'b01);
    add(3'b000, 2'b00, 2'b00);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.ctrl_strobe = vecs[i].strobe;
      bus.ctrl_rd     = vecs[i].rd;
      #1;
      check($sformatf("vec %0d ctrl_data", i), 32'(bus.ctrl_data), 32'(vecs[i].exp_data));
    end

    // Strobe held high while reads pulse; pad changes to 8'h00
    @(negedge clk);
    bus.ctrl_strobe = 3'b001;
    bus.ctrl_rd     = 2'b00;
    pad_btn0        = 8'h00;
    got = -1; bad = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      bus.ctrl_rd = {1'b0, ~bus.ctrl_rd[0]};
      tick();
      if (bus.buttons0 == 8'h00) begin
        got = k;
        break;
      end
      if (bus.ctrl_data[0] !== 1'b1) bad = 1'b1;
    end
    check("strobe holds data0, no shift", 32'(bad), 32'(0));
    check("second commit seen", 32'(got >= 0), 32'(1));
    check("data0 at commit edge", 32'(bus.ctrl_data[0]), 32'(1));
    @(negedge clk);
    bus.ctrl_rd = 2'b00;
    tick();
    check("data0 one cycle after commit", 32'(bus.ctrl_data[0]), 32'(0));

    // Commit of 8'hFF while mid-shift must not disturb the old sequence
    @(negedge clk);
    bus.ctrl_strobe = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ctrl_rd = 2'b01;
      #1;
      check($sformatf("pre-commit read %0d", i), 32'(bus.ctrl_data[0]), 32'(0));
    end
    @(negedge clk);
    bus.ctrl_rd = 2'b00;
    pad_btn0    = 8'hFF;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (bus.buttons0 == 8'hFF) begin
        found = 1'b1;
        break;
      end
    end
    check("FF commit seen", 32'(found), 32'(1));
    check("buttons1 kept", 32'(bus.buttons1), 32'(8'hA0));
    for (int i = 3; i < 9; i++) begin
      @(negedge clk);
      bus.ctrl_rd = 2'b01;
      #1;
      check($sformatf("post-commit read %0d", i), 32'(bus.ctrl_data[0]), 32'(i == 8));
    end
    @(negedge clk);
    bus.ctrl_rd     = 2'b00;
    bus.ctrl_strobe = 3'b001;
    tick();
    check("strobe to data next cycle", 32'(bus.ctrl_data), 32'(2'b01));
    @(negedge clk);
    bus.ctrl_strobe = 3'b000;

    // Reset asserted during HIGH(3)
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (bus.pad_latch) begin
        found = 1'b1;
        break;
      end
    end
    check("latch before mid-frame reset", 32'(found), 32'(1));
    pulses = 0; prev_clk = 1'b0;
    for (int k = 0; k < 100 && pulses < 4; k++) begin
      tick();
      if (bus.pad_clk && !prev_clk) pulses++;
      prev_clk = bus.pad_clk;
    end
    check("reached HIGH(3)", 32'(pulses), 32'(4));
    check("data before reset", 32'(bus.ctrl_data), 32'(2'b01));
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid-frame reset pad_clk", 32'(bus.pad_clk), 32'(0));
    check("mid-frame reset pad_latch", 32'(bus.pad_latch), 32'(0));
    check("mid-frame reset buttons", 32'({bus.buttons1, bus.buttons0}), 32'(0));
    check("mid-frame reset ctrl_data", 32'(bus.ctrl_data), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_then_latch("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
